// File: rtl/uart_pkg.sv
// Shared UART definitions: line-rate defaults, bit-timing helper and the
// receive/transmit FSM state encoding.
package uart_pkg;

  localparam int unsigned BAUD_DEFAULT = 9600;
  localparam int unsigned FREQ_DEFAULT = 12000000;
  localparam int          CNT_W        = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  function automatic int unsigned cycles_per_bit(input int unsigned freq,
                                                 input int unsigned baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input; flops reset to
// RST_VAL so an idle-high line does not look like an edge after reset.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic nrst,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: falling-edge start detect, mid-bit sampling, single-entry
// output register with rd_ack handshake and sticky overrun.
// Handshake: data_valid stays high until rd_ack is sampled high; a byte
// accepted in the same cycle as rd_ack replaces the one being acknowledged.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD = BAUD_DEFAULT,
  parameter int unsigned FREQ = FREQ_DEFAULT
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       rx,
  input  logic       rd_ack,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned LIM  = cycles_per_bit(FREQ, BAUD);
  localparam int unsigned HALF = LIM / 2;
  localparam logic [CNT_W-1:0] LIM_M1  = CNT_W'(LIM - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);

  logic rx_s;
  logic hist_q, hist_d;
  logic fall;
  logic accept;

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk  (clk),
    .nrst (nrst),
    .d    (rx),
    .q    (rx_s)
  );

  // A line held low keeps hist_q low, so it cannot retrigger a start.
  assign fall = hist_q & ~rx_s;

  always_comb begin
    hist_d       = rx_s;
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    frame_err_d  = 1'b0;
    accept       = 1'b0;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    overrun_d    = overrun_q;

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          cnt_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == LIM_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'd7) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == LIM_M1) begin
          cnt_d       = '0;
          state_d     = ST_IDLE;
          accept      = rx_s;
          frame_err_d = ~rx_s;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear first so that an overrun raised in this same cycle takes priority.
    if (rd_ack) overrun_d = 1'b0;

    if (accept) begin
      if (!data_valid_q || rd_ack) begin
        data_out_d   = shift_q;
        data_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rd_ack) begin
      data_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hist_q       <= 1'b1;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      hist_q       <= hist_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter BAUD, default 9600: line bit rate in bits/s.
REQ-002 Parameter FREQ, default 12000000: clk frequency in Hz.
REQ-003 Derived constant LIM = FREQ/BAUD (1250 at defaults), clk cycles per bit; HALF = LIM/2 (625).
REQ-004 Port clk, input, 1 bit: the single clock; every flop is clocked on its rising edge.
REQ-005 Port nrst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port rx, input, 1 bit: serial line; asynchronous to clk; idles high; frame is 8N1, LSB first.
REQ-007 Port rd_ack, input, 1 bit: consumer acknowledges data_out.
REQ-008 Port data_out, output, 8 bits: last accepted byte.
REQ-009 Port data_valid, output, 1 bit: data_out holds an unread byte.
REQ-010 Port frame_err, output, 1 bit: one-cycle pulse when a stop bit is sampled low.
REQ-011 Port overrun, output, 1 bit: sticky flag, a byte was lost.
REQ-012 Port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-013 rx passes through a 2-flop synchronizer (flops reset to 1) plus one history flop; falling-edge detect = history 1, synced 0.
REQ-014 FSM states: IDLE, START, DATA, STOP; bit counter 11 bits wide; data-bit index 3 bits wide.
REQ-015 IDLE: on a detected falling edge, clear the counter and enter START; a line held low does not retrigger.
REQ-016 START: when the counter reaches HALF-1, sample the synced rx; 0 -> clear the counter, enter DATA; 1 -> return to IDLE (glitch reject, no flags).
REQ-017 DATA: every LIM cycles (counter LIM-1 then wrap to 0), shift the synced rx into the MSB of the shift register (LSB-first reception); after the 8th sample, enter STOP.
REQ-018 STOP: after LIM cycles, sample; 1 -> byte accepted; 0 -> frame_err high for exactly 1 cycle, byte discarded; both cases -> IDLE.
REQ-019 On acceptance with data_valid=0: data_out <= shift register, data_valid <= 1 on the next edge.
REQ-020 data_valid holds until rd_ack is sampled high; the cycle after, data_valid = 0. rd_ack with data_valid=0 is ignored.
REQ-021 Acceptance with data_valid=1 and rd_ack=0: new byte discarded, data_out unchanged, overrun <= 1.
REQ-022 Acceptance with data_valid=1 and rd_ack=1 in the same cycle: new byte loaded, data_valid stays 1, no overrun.
REQ-023 overrun clears on rd_ack (unless REQ-021 sets it in the same cycle; set wins).
REQ-024 Latency: data_valid rises no later than LIM*9 + HALF + 4 cycles after the rx start-bit falling edge.

Reset
REQ-025 While nrst=0: FSM = IDLE, counters = 0, shift register = 0, synchronizer/history = 1, data_out = 0x00, data_valid = 0, frame_err = 0, overrun = 0, busy = 0.
REQ-026 Reset asserted mid-frame aborts the frame with no flags; after release the block waits for a fresh falling edge.

Structure
REQ-027 BAUD/FREQ defaults, LIM/HALF derivation and FSM state encodings live in the shared uart package, shared with the transmitter.
REQ-028 The synchronizer is a separate sub-module, uart_sync2, reused by any other async inputs.

Verification
REQ-029 Send 0x53 at 9600 baud -> data_valid=1, data_out=0x53, frame_err=0; rd_ack -> data_valid=0 the next cycle.
REQ-030 Drive a 300-cycle low glitch on idle rx -> busy pulses, then IDLE; data_valid, frame_err and overrun all stay 0.
REQ-031 Send 0xA5 with its stop bit low -> frame_err one-cycle pulse, data_valid stays 0; the following 0x3C is received correctly.
REQ-032 Send 0x11 then 0x22 with no ack -> data_out=0x11, overrun=1; rd_ack clears both data_valid and overrun.
REQ-033 Assert rd_ack in the exact cycle 0x7E is accepted while 0x11 is pending -> data_out=0x7E, data_valid=1, overrun=0.
REQ-034 Pulse nrst low during data bit 4 of 0xFF -> all outputs are at reset values; a subsequent 0x00 is received correctly.
